acess_ctrl_mem: RTL and testbench

- Parametrised successor to the single-password access controller.
- Checks a typed password against a small on-chip table of up to PROFUNDIDADE programmable passwords, scanning one entry per cycle.
- Reports grant or deny as timed pulses and counts consecutive failures.
- Enters a timed lockout after MAX_FALHAS consecutive denials; sits between the keypad/input logic and the door/actuator logic.

---
 rtl/acess_ctrl_mem_if.sv | 33 +++
 rtl/acess_ctrl_mem.sv | 147 ++++++++++++++
 tb/tb_acess_ctrl_mem.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acess_ctrl_mem_if.sv
// Keypad/programming port bundle of the multi-password access controller.
// master = keypad/host side, slave = controller side.
interface acess_ctrl_mem_if #(
    parameter int LARGURA      = 8,
    parameter int PROFUNDIDADE = 4,
    parameter int MAX_FALHAS   = 3
);
    localparam int AW = $clog2(PROFUNDIDADE);
    localparam int FW = $clog2(MAX_FALHAS + 1);

    logic               enter;
    logic [LARGURA-1:0] senha_digitada;
    logic               prog_we;
    logic [AW-1:0]      prog_addr;
    logic [LARGURA-1:0] prog_data;
    logic               prog_valid;
    logic               prog_ok;
    logic               resultado;
    logic               negado;
    logic               bloqueado;
    logic [AW-1:0]      indice_match;
    logic [FW-1:0]      falhas;

    modport master (
        output enter, senha_digitada, prog_we, prog_addr, prog_data, prog_valid,
        input  prog_ok, resultado, negado, bloqueado, indice_match, falhas
    );

    modport slave (
        input  enter, senha_digitada, prog_we, prog_addr, prog_data, prog_valid,
        output prog_ok, resultado, negado, bloqueado, indice_match, falhas
    );
endinterface

// File: rtl/acess_ctrl_mem.sv
// Access controller: scans a programmable password table one entry per cycle,
// pulses grant/deny, counts consecutive denials and enforces a timed lockout.
module acess_ctrl_mem #(
    parameter int LARGURA      = 8,
    parameter int PROFUNDIDADE = 4,
    parameter int MAX_FALHAS   = 3,
    parameter int BLOQ_CICLOS  = 50,
    parameter int PULSO_CICLOS = 4,
    parameter int SENHA_PADRAO = 146
) (
    input logic              clk,
    input logic              rst,
    acess_ctrl_mem_if.slave  bus
);
    localparam int AW   = $clog2(PROFUNDIDADE);
    localparam int FW   = $clog2(MAX_FALHAS + 1);
    localparam int CMAX = (BLOQ_CICLOS > PULSO_CICLOS) ? BLOQ_CICLOS : PULSO_CICLOS;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [AW-1:0]      LAST_IDX   = AW'(PROFUNDIDADE - 1);
    localparam logic [FW-1:0]      FALHAS_MAX = FW'(MAX_FALHAS);
    localparam logic [CW-1:0]      PULSO_LAST = CW'(PULSO_CICLOS - 1);
    localparam logic [CW-1:0]      BLOQ_LAST  = CW'(BLOQ_CICLOS - 1);
    localparam logic [LARGURA-1:0] SENHA_RST  = LARGURA'(SENHA_PADRAO);

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        GRANT,
        DENY,
        LOCKED
    } state_t;

    state_t state, state_n;

    logic                enter_q;
    logic [LARGURA-1:0]  reg_senha;
    logic [LARGURA-1:0]  mem [PROFUNDIDADE];
    logic [PROFUNDIDADE-1:0] mem_vld;
    logic [AW-1:0]       idx;
    logic [AW-1:0]       cmp_idx;
    logic                cmp_vld;
    logic                cmp_hit;
    logic                cmp_last;
    logic [CW-1:0]       cnt;
    logic [FW-1:0]       falhas_q;
    logic [AW-1:0]       indice_q;
    logic                prog_ok_q;

    logic start;
    logic accept;
    logic cnt_done;

    // A start exists only in IDLE; it also blocks a same-cycle table write.
    assign start    = (state == IDLE) && bus.enter && !enter_q;
    assign accept   = (state == IDLE) && bus.prog_we && !start;
    assign cnt_done = (state == LOCKED) ? (cnt == BLOQ_LAST) : (cnt == PULSO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // SEARCH decides on the compare registered one cycle earlier, so a hit at
    // entry i is acted on two cycles after the start edge plus i.
    always_comb begin
        // NOTE: default first so every path assigns state_n and no latch is inferred.
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SEARCH;
            SEARCH: begin
                if (cmp_vld && cmp_hit)       state_n = GRANT;
                else if (cmp_vld && cmp_last) state_n = DENY;
            end
            GRANT:   if (cnt_done) state_n = IDLE;
            DENY:    if (cnt_done) state_n = (falhas_q == FALHAS_MAX) ? LOCKED : IDLE;
            LOCKED:  if (cnt_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_q   <= 1'b0;
            reg_senha <= '0;
            idx       <= '0;
            cmp_idx   <= '0;
            cmp_vld   <= 1'b0;
            cmp_hit   <= 1'b0;
            cmp_last  <= 1'b0;
            cnt       <= '0;
            falhas_q  <= '0;
            indice_q  <= '0;
            prog_ok_q <= 1'b0;
            // NOTE: the table is small and must come back to its default
            // contents on every reset, so it is built from flops, not a RAM.
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                mem[i]     <= (i == 0) ? SENHA_RST : '0;
                mem_vld[i] <= (i == 0);
            end
        end else begin
            // NOTE: non-blocking everywhere here; every flop sees pre-edge values.
            enter_q   <= bus.enter;
            prog_ok_q <= accept;

            if (accept) begin
                mem[bus.prog_addr]     <= bus.prog_data;
                mem_vld[bus.prog_addr] <= bus.prog_valid;
            end

            if (start) begin
                reg_senha <= bus.senha_digitada;
                idx       <= '0;
                cmp_vld   <= 1'b0;
            end

            if (state == SEARCH) begin
                cmp_vld  <= 1'b1;
                cmp_hit  <= mem_vld[idx] && (mem[idx] == reg_senha);
                cmp_last <= (idx == LAST_IDX);
                cmp_idx  <= idx;
                if (idx != LAST_IDX) idx <= idx + 1'b1;
            end

            if (state_n != state)
                cnt <= '0;
            else if ((state == GRANT || state == DENY || state == LOCKED) && !cnt_done)
                cnt <= cnt + 1'b1;

            if (state == SEARCH && state_n == GRANT) begin
                indice_q <= cmp_idx;
                falhas_q <= '0;
            end else if (state == SEARCH && state_n == DENY && falhas_q != FALHAS_MAX) begin
                falhas_q <= falhas_q + 1'b1;
            end else if (state == LOCKED && cnt_done) begin
                falhas_q <= '0;
            end
        end
    end

    assign bus.resultado    = (state == GRANT);
    assign bus.negado       = (state == DENY);
    assign bus.bloqueado    = (state == LOCKED);
    assign bus.prog_ok      = prog_ok_q;
    assign bus.indice_match = indice_q;
    assign bus.falhas       = falhas_q;
endmodule

// File: tb/tb_acess_ctrl_mem.sv
// Scoreboard bench for acess_ctrl_mem: the driver pushes expected responses
// from a table model, a negedge monitor pops and compares them.
module tb_acess_ctrl_mem;
    localparam int LARG  = 8;
    localparam int PROF  = 4;
    localparam int MAXF  = 3;
    localparam int BLOQ  = 50;
    localparam int PULSO = 4;
    localparam int SENHA = 146;

    typedef enum int {E_GRANT, E_DENY, E_PROG, E_LOCK} ek_t;
    typedef struct {
        ek_t kind;
        int  idx;
        int  falhas;
        int  stamp;
        int  lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];

    logic [LARG-1:0] m_val [PROF];
    bit              m_vld [PROF];
    int              m_falhas;
    logic [LARG-1:0] pool  [5];

    acess_ctrl_mem_if #(.LARGURA(LARG), .PROFUNDIDADE(PROF), .MAX_FALHAS(MAXF)) bus ();

    acess_ctrl_mem #(
        .LARGURA(LARG), .PROFUNDIDADE(PROF), .MAX_FALHAS(MAXF),
        .BLOQ_CICLOS(BLOQ), .PULSO_CICLOS(PULSO), .SENHA_PADRAO(SENHA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < PROF; i++) begin
            m_val[i] = (i == 0) ? LARG'(SENHA) : '0;
            m_vld[i] = (i == 0);
        end
        m_falhas = 0;
    endtask

    // First valid matching entry grants; otherwise deny, possibly followed by lockout.
    task automatic expect_check(input logic [LARG-1:0] s, input int stamp);
        int hit = -1;
        for (int i = 0; i < PROF; i++)
            if (hit < 0 && m_vld[i] && m_val[i] == s) hit = i;
        if (hit >= 0) begin
            m_falhas = 0;
            q.push_back('{E_GRANT, hit, 0, stamp, hit + 2});
        end else begin
            if (m_falhas < MAXF) m_falhas++;
            q.push_back('{E_DENY, 0, m_falhas, stamp, PROF + 1});
            if (m_falhas == MAXF) begin
                q.push_back('{E_LOCK, 0, MAXF, 0, 0});
                m_falhas = 0;
            end
        end
    endtask

    task automatic send_check(input logic [LARG-1:0] s, input bit expect_it);
        @(negedge clk);
        bus.senha_digitada = s;
        bus.enter = 1'b1;
        if (expect_it) expect_check(s, cyc + 1);
        @(negedge clk);
        bus.enter = 1'b0;
    endtask

    task automatic send_prog(input int a, input logic [LARG-1:0] d, input bit v,
                             input bit with_start, input logic [LARG-1:0] s);
        @(negedge clk);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = 2'(a);
        bus.prog_data  = d;
        bus.prog_valid = v;
        if (with_start) begin
            bus.enter = 1'b1;
            bus.senha_digitada = s;
            expect_check(s, cyc + 1);
        end else begin
            m_val[a] = d;
            m_vld[a] = v;
            q.push_back('{E_PROG, 0, 0, cyc + 1, 0});
        end
        @(negedge clk);
        bus.prog_we = 1'b0;
        bus.enter   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((q.size() != 0 || bus.resultado || bus.negado || bus.bloqueado) && n < 400);
        check("wait_idle_timeout", (n < 400), 1);
        @(negedge clk);
    endtask

    task automatic wait_locked();
        int n = 0;
        while (!bus.bloqueado && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("lock_entry", bus.bloqueado, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_resultado"}, bus.resultado, 0);
        check({tag, "_negado"}, bus.negado, 0);
        check({tag, "_bloqueado"}, bus.bloqueado, 0);
        check({tag, "_prog_ok"}, bus.prog_ok, 0);
        check({tag, "_falhas"}, bus.falhas, 0);
        check({tag, "_indice"}, bus.indice_match, 0);
    endtask

    task automatic reset_mid(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.enter = 1'b0;
        bus.prog_we = 1'b0;
        #1;
        check_all_zero(tag);
        q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops one expectation per observed response and measures pulse widths.
    logic pr_res, pr_neg, pr_lock, pr_ok;
    int   res_w, neg_w, lock_w, ok_w;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pr_res = 0; pr_neg = 0; pr_lock = 0; pr_ok = 0;
            res_w = 0; neg_w = 0; lock_w = 0; ok_w = 0;
        end else begin
            if (bus.resultado && bus.negado) check("grant_deny_exclusive", 1, 0);

            if (bus.resultado && !pr_res) begin
                if (q.size() == 0) check("grant_expected", q.size(), 1);
                else begin
                    e = q.pop_front();
                    check("grant_kind", e.kind, E_GRANT);
                    check("grant_latency", cyc - e.stamp, e.lat);
                    check("grant_indice", bus.indice_match, e.idx);
                    check("grant_falhas", bus.falhas, e.falhas);
                end
            end
            if (bus.negado && !pr_neg) begin
                if (q.size() == 0) check("deny_expected", q.size(), 1);
                else begin
                    e = q.pop_front();
                    check("deny_kind", e.kind, E_DENY);
                    check("deny_latency", cyc - e.stamp, e.lat);
                    check("deny_falhas", bus.falhas, e.falhas);
                end
            end
            if (bus.prog_ok && !pr_ok) begin
                if (q.size() == 0) check("prog_ok_expected", q.size(), 1);
                else begin
                    e = q.pop_front();
                    check("prog_kind", e.kind, E_PROG);
                    check("prog_latency", cyc - e.stamp, e.lat);
                end
            end
            if (bus.bloqueado && !pr_lock) begin
                if (q.size() == 0) check("lock_expected", q.size(), 1);
                else begin
                    e = q.pop_front();
                    check("lock_kind", e.kind, E_LOCK);
                    check("lock_falhas", bus.falhas, e.falhas);
                end
            end

            if (bus.resultado) res_w++;
            else if (pr_res) begin check("grant_width", res_w, PULSO); res_w = 0; end
            if (bus.negado) neg_w++;
            else if (pr_neg) begin check("deny_width", neg_w, PULSO); neg_w = 0; end
            if (bus.prog_ok) ok_w++;
            else if (pr_ok) begin check("prog_ok_width", ok_w, 1); ok_w = 0; end
            if (bus.bloqueado) lock_w++;
            else if (pr_lock) begin
                check("lock_width", lock_w, BLOQ);
                check("lock_exit_falhas", bus.falhas, 0);
                lock_w = 0;
            end

            pr_res = bus.resultado; pr_neg = bus.negado;
            pr_lock = bus.bloqueado; pr_ok = bus.prog_ok;
        end
    end

    initial begin
        pool = '{8'd146, 8'd199, 8'd1, 8'd33, 8'd250};
        bus.enter = 1'b0;
        bus.senha_digitada = '0;
        bus.prog_we = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.prog_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Default password, then two wrong ones, then lockout.
        send_check(8'd146, 1); wait_idle();
        send_check(8'd1, 1);   wait_idle();
        send_check(8'd199, 1); wait_idle();
        check("no_lock_after_two", bus.bloqueado, 0);
        send_check(8'd7, 1);
        wait_locked();
        send_check(8'd146, 0);
        wait_idle();
        send_check(8'd146, 1); wait_idle();

        // Programming, then a grant from entry 2.
        send_prog(2, 8'd199, 1'b1, 1'b0, 8'd0); wait_idle();
        send_check(8'd199, 1); wait_idle();

        // Invalidate entry 0; default password must now be denied.
        send_prog(0, 8'd146, 1'b0, 1'b0, 8'd0); wait_idle();
        send_check(8'd146, 1); wait_idle();

        // Enter held high: one check only.
        @(negedge clk);
        bus.senha_digitada = 8'd199;
        bus.enter = 1'b1;
        expect_check(8'd199, cyc + 1);
        repeat (30) @(negedge clk);
        bus.enter = 1'b0;
        wait_idle();

        // Second rising edge during SEARCH and a write during SEARCH are both dropped.
        send_check(8'd199, 1);
        @(negedge clk); bus.enter = 1'b1;
        @(negedge clk); bus.enter = 1'b0;
        bus.prog_we = 1'b1; bus.prog_addr = 2'd1; bus.prog_data = 8'd33; bus.prog_valid = 1'b1;
        @(negedge clk); bus.prog_we = 1'b0;
        wait_idle();
        send_check(8'd33, 1); wait_idle();

        // Start and write in the same cycle: the start wins.
        send_prog(3, 8'd250, 1'b1, 1'b1, 8'd199); wait_idle();
        send_check(8'd250, 1); wait_idle();

        // Reset mid-search restores the table.
        send_check(8'd199, 1);
        reset_mid("rst_search");
        repeat (2) @(negedge clk);
        send_check(8'd146, 1); wait_idle();
        send_check(8'd199, 1); wait_idle();

        // Reset mid-lockout.
        send_check(8'd1, 1); wait_idle();
        send_check(8'd2, 1);
        wait_locked();
        repeat (10) @(negedge clk);
        reset_mid("rst_locked");
        repeat (2) @(negedge clk);
        send_check(8'd146, 1); wait_idle();

        // Randomised traffic against the table model.
        for (int k = 0; k < 40; k++) begin
            int r;
            r = $urandom_range(0, 5);
            if (r == 0)
                send_prog($urandom_range(0, PROF - 1), pool[$urandom_range(0, 4)],
                          1'($urandom_range(0, 1)), 1'b0, 8'd0);
            else if (r == 1)
                send_prog($urandom_range(0, PROF - 1), pool[$urandom_range(0, 4)],
                          1'b1, 1'b1, pool[$urandom_range(0, 4)]);
            else
                send_check(pool[$urandom_range(0, 4)], 1);
            wait_idle();
        end

        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
